// File: rtl/qqspi_arb_pkg.sv
// Shared types for the two-master qqspi arbiter.
// State encoding, master indices and counter width.
package qqspi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/qqspi_arb_pick.sv
// Combinational winner selection for qqspi_arbiter.
// QQSPI_ARB_RR_EN selects round-robin; default is fixed priority with a starvation guard.
module qqspi_arb_pick
  import qqspi_arb_pkg::*;
#(
  parameter int MAX_CONSEC = 4
) (
  input  logic             m0_valid,
  input  logic             m1_valid,
`ifdef QQSPI_ARB_RR_EN
  input  logic             last_grant,
`else
  input  logic [CNT_W-1:0] consec,
`endif
  output logic             winner
);

  logic tie;

`ifdef QQSPI_ARB_RR_EN
  assign tie = ~last_grant;
`else
  localparam logic [CNT_W-1:0] MAX_C =
    CNT_W'(MAX_CONSEC);

  // m1 only breaks through once m0 has used up its burst
  assign tie = (consec == MAX_C) ? M_AUX : M_CPU;
`endif

  always_comb begin
    winner = M_CPU;
    unique case (1'b1)
      m0_valid && m1_valid:  winner = tie;
      !m0_valid && m1_valid: winner = M_AUX;
      default:               winner = M_CPU;
    endcase
  end

endmodule

// File: rtl/qqspi_arbiter.sv
// Two-master arbiter in front of the single qqspi controller.
// Build with QQSPI_ARB_RR_EN for round-robin instead of fixed priority.
module qqspi_arbiter
  import qqspi_arb_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  input  logic              m0_psram,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  input  logic              m1_psram,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  output logic              s_psram,
  input  logic              s_ready,
  input  logic [31:0]       s_rdata,
  output logic              grant
);

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              psram_q, psram_d;
  logic              winner;

`ifndef QQSPI_ARB_RR_EN
  localparam logic [CNT_W-1:0] MAX_C =
    CNT_W'(MAX_CONSEC);

  logic [CNT_W-1:0] consec_q, consec_d;
`endif

  qqspi_arb_pick #(
    .MAX_CONSEC(MAX_CONSEC)
  ) u_pick (
    .m0_valid  (m0_valid),
    .m1_valid  (m1_valid),
`ifdef QQSPI_ARB_RR_EN
    .last_grant(grant_q),
`else
    .consec    (consec_q),
`endif
    .winner    (winner)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    psram_d  = psram_q;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
`ifndef QQSPI_ARB_RR_EN
    consec_d = consec_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = BUSY;
          grant_d = winner;
          if (winner == M_AUX) begin
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
            wstrb_d = m1_wstrb;
            psram_d = m1_psram;
          end else begin
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
            wstrb_d = m0_wstrb;
            psram_d = m0_psram;
          end
`ifndef QQSPI_ARB_RR_EN
          // only m0 grants that bypass a waiting m1 count
          if (winner == M_AUX || !m1_valid)
            consec_d = '0;
          else if (consec_q != MAX_C)
            consec_d = consec_q + 1'b1;
`endif
        end
      end
      BUSY: begin
        if (s_ready) begin
          state_d = DONE;
          if (grant_q == M_AUX) m1_ready = 1'b1;
          else                  m0_ready = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      grant_q  <= M_CPU;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      psram_q  <= 1'b0;
`ifndef QQSPI_ARB_RR_EN
      consec_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      psram_q  <= psram_d;
`ifndef QQSPI_ARB_RR_EN
      consec_q <= consec_d;
`endif
    end
  end

  assign s_valid  = (state_q == BUSY);
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_wstrb  = wstrb_q;
  assign s_psram  = psram_q;
  assign grant    = grant_q;
  assign m0_rdata = (grant_q == M_CPU) ? s_rdata : '0;
  assign m1_rdata = (grant_q == M_AUX) ? s_rdata : '0;

endmodule

// File: tb/tb_qqspi_arbiter.sv
// Directed scoreboard bench for qqspi_arbiter with a simple qqspi responder.
// Honours QQSPI_ARB_RR_EN for the tie-break expectations.
module tb_qqspi_arbiter;

  localparam int AW = 23;

  logic          clk      = 1'b0;
  logic          resetn   = 1'b0;
  logic          m0_valid = 1'b0;
  logic [AW-1:0] m0_addr  = '0;
  logic [31:0]   m0_wdata = '0;
  logic [3:0]    m0_wstrb = '0;
  logic          m0_psram = 1'b0;
  logic          m0_ready;
  logic [31:0]   m0_rdata;
  logic          m1_valid = 1'b0;
  logic [AW-1:0] m1_addr  = '0;
  logic [31:0]   m1_wdata = '0;
  logic [3:0]    m1_wstrb = '0;
  logic          m1_psram = 1'b0;
  logic          m1_ready;
  logic [31:0]   m1_rdata;
  logic          s_valid;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic          s_psram;
  logic          s_ready  = 1'b0;
  logic [31:0]   s_rdata  = '0;
  logic          grant;

  always #5 clk = ~clk;

  qqspi_arbiter #(
    .ADDR_W    (AW),
    .MAX_CONSEC(4)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .m0_valid(m0_valid),
    .m0_addr (m0_addr),
    .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb),
    .m0_psram(m0_psram),
    .m0_ready(m0_ready),
    .m0_rdata(m0_rdata),
    .m1_valid(m1_valid),
    .m1_addr (m1_addr),
    .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb),
    .m1_psram(m1_psram),
    .m1_ready(m1_ready),
    .m1_rdata(m1_rdata),
    .s_valid (s_valid),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_psram (s_psram),
    .s_ready (s_ready),
    .s_rdata (s_rdata),
    .grant   (grant)
  );

  typedef struct packed {
    logic        m;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   pushes = 0;
  logic last_g = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_txn(input logic m,
                            input logic [31:0] d);
    exp_t e;
    e.m = m;
    e.d = d;
    sb.push_back(e);
    pushes++;
  endtask

  // qqspi responder: waits for s_valid, checks the latched
  // request, answers after lat cycles with rd
  task automatic serve_m(input logic g, input int lat,
                         input logic [31:0] rd);
    int n;
    n = 0;
    while (s_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("s_valid_wait", 32'(s_valid), 32'd1);
    check("grant", 32'(grant), 32'(g));
    check("s_addr", 32'(s_addr),
          g ? 32'(m1_addr) : 32'(m0_addr));
    check("s_wdata", s_wdata, g ? m1_wdata : m0_wdata);
    check("s_wstrb", 32'(s_wstrb),
          g ? 32'(m1_wstrb) : 32'(m0_wstrb));
    check("s_psram", 32'(s_psram),
          g ? 32'(m1_psram) : 32'(m0_psram));
    for (int i = 1; i < lat; i++) begin
      step();
      check("s_valid_hold", 32'(s_valid), 32'd1);
    end
    s_ready = 1'b1;
    s_rdata = rd;
    step();
    s_ready = 1'b0;
    s_rdata = '0;
    last_g  = g;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m0_ready || m1_ready) begin
      pulses++;
      if (sb.size() == 0) begin
        check("unexpected_ready",
              32'({m1_ready, m0_ready}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ready_owner", 32'({m1_ready, m0_ready}),
              e.m ? 32'd2 : 32'd1);
        check("rdata", e.m ? m1_rdata : m0_rdata, e.d);
        check("other_rdata",
              e.m ? m0_rdata : m1_rdata, 32'd0);
      end
    end
  end

  initial begin
    logic [9:0] seq;
    logic       first;
    logic       g;

    // reset state
    resetn = 1'b0;
    repeat (2) step();
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_s_addr", 32'(s_addr), 32'd0);
    check("rst_s_wdata", s_wdata, 32'd0);
    check("rst_s_wstrb", 32'(s_wstrb), 32'd0);
    check("rst_s_psram", 32'(s_psram), 32'd0);
    check("rst_m0_ready", 32'(m0_ready), 32'd0);
    check("rst_m1_ready", 32'(m1_ready), 32'd0);
    resetn = 1'b1;
    last_g = 1'b0;
    step();

    // single m0 flash read
    m0_addr  = 23'h000100;
    m0_wdata = '0;
    m0_wstrb = 4'h0;
    m0_psram = 1'b0;
    m0_valid = 1'b1;
    expect_txn(1'b0, 32'hDEADBEEF);
    check("s_valid_same_cycle", 32'(s_valid), 32'd0);
    step();
    check("s_valid_next_cycle", 32'(s_valid), 32'd1);
    serve_m(1'b0, 3, 32'hDEADBEEF);
    m0_valid = 1'b0;
    step();

    // simultaneous requests
    m0_addr  = 23'h000200;
    m0_wstrb = 4'h0;
    m0_psram = 1'b0;
    m1_addr  = 23'h004000;
    m1_wdata = 32'h12345678;
    m1_wstrb = 4'hF;
    m1_psram = 1'b1;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
`ifdef QQSPI_ARB_RR_EN
    first = ~last_g;
`else
    first = 1'b0;
`endif
    expect_txn(first, 32'h0000_1111);
    expect_txn(~first, 32'h0000_2222);
    serve_m(first, 2, 32'h0000_1111);
    if (first) m1_valid = 1'b0;
    else       m0_valid = 1'b0;
    serve_m(~first, 2, 32'h0000_2222);
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    step();

    // both continuously valid: starvation guard / alternation
    seq = 10'b10_0001_0000;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
`ifdef QQSPI_ARB_RR_EN
      g = ~last_g;
`else
      g = seq[i];
`endif
      expect_txn(g, 32'hA000_0000 + 32'(i));
      serve_m(g, 1 + (i % 3), 32'hA000_0000 + 32'(i));
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    step();

    // reset two cycles into BUSY with s_ready offered
    m1_addr  = 23'h07ABCD;
    m1_wdata = '0;
    m1_wstrb = 4'h0;
    m1_psram = 1'b1;
    m1_valid = 1'b1;
    step();
    check("rst_busy_s_valid", 32'(s_valid), 32'd1);
    step();
    s_ready = 1'b1;
    s_rdata = 32'hFFFF_FFFF;
    resetn  = 1'b0;
    #1;
    check("async_rst_s_valid", 32'(s_valid), 32'd0);
    check("async_rst_m1_ready", 32'(m1_ready), 32'd0);
    check("async_rst_m0_ready", 32'(m0_ready), 32'd0);
    step();
    s_ready = 1'b0;
    s_rdata = '0;
    resetn  = 1'b1;
    last_g  = 1'b0;
    expect_txn(1'b1, 32'h0BADF00D);
    serve_m(1'b1, 2, 32'h0BADF00D);
    m1_valid = 1'b0;
    step();

    // m1 drops valid mid-BUSY
    m1_addr  = 23'h001234;
    m1_wdata = 32'h0000_55AA;
    m1_wstrb = 4'h3;
    m1_psram = 1'b0;
    m1_valid = 1'b1;
    expect_txn(1'b1, 32'h1111_2222);
    step();
    m1_valid = 1'b0;
    serve_m(1'b1, 3, 32'h1111_2222);
    step();
    check("idle_after_drop", 32'(s_valid), 32'd0);

    // stray s_ready in IDLE
    s_ready = 1'b1;
    s_rdata = 32'h0000_CAFE;
    step();
    s_ready = 1'b0;
    s_rdata = '0;
    check("stray_ready_s_valid", 32'(s_valid), 32'd0);

    // arbiter still serves new work
    m0_addr  = 23'h0003FF;
    m0_wstrb = 4'h0;
    m0_psram = 1'b1;
    m0_valid = 1'b1;
    expect_txn(1'b0, 32'h600D_CAFE);
    serve_m(1'b0, 2, 32'h600D_CAFE);
    m0_valid = 1'b0;
    repeat (3) step();

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("pulse_count", 32'(pulses), 32'(pushes));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
